// File: rtl/fir_coeff_sequencer.sv
// fir_coeff_sequencer
// Loads the FIR tap coefficients from a synchronous-read coefficient memory,
// keeps the filter disabled while loading, then gates samples into the tap
// chain and flags when the delay line holds a full post-load window.
module fir_coeff_sequencer #(
    parameter int N_TAPS    = 71,
    parameter int COEFF_W   = 8,
    parameter int ADDR_W    = 7,
    parameter bit AUTO_LOAD = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_req,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [COEFF_W-1:0] mem_rdata,
    output logic               tap_we,
    output logic [ADDR_W-1:0]  tap_addr,
    output logic [COEFF_W-1:0] tap_data,
    input  logic               x_valid_in,
    output logic               fir_en,
    output logic               coeff_loaded,
    output logic               busy,
    output logic               y_valid
);

    // The sample counter must be able to hold N_TAPS itself (saturation value).
    localparam int                 CNT_W     = $clog2(N_TAPS + 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(N_TAPS - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(N_TAPS);
    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(N_TAPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        LAST = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                start_load;
    logic                auto_pend;

    logic                rd_vld_p0;
    logic [ADDR_W-1:0]   rd_addr_p0;
    logic                wr_vld_p1;
    logic [ADDR_W-1:0]   wr_addr_p1;

    logic [CNT_W-1:0]    smp_cnt;
    logic                run_en;

    // Saturating increment: the window counter sticks at N_TAPS once reached.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= CNT_MAX) begin
            return CNT_MAX;
        end
        return v + 1'b1;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a load request is only honoured from IDLE or RUN.
    always_comb begin
        state_nxt  = state;
        start_load = 1'b0;
        case (state)
            IDLE: begin
                if (load_req || auto_pend) begin
                    state_nxt  = READ;
                    start_load = 1'b1;
                end
            end
            READ: begin
                if (rd_addr_p0 == LAST_ADDR) begin
                    state_nxt = LAST;
                end
            end
            LAST: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (load_req) begin
                    state_nxt  = READ;
                    start_load = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // One-shot flag that makes the first edge after reset release start a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_pend <= AUTO_LOAD;
        end else begin
            auto_pend <= 1'b0;
        end
    end

    // ---- stage p0: memory read address and strobe ----
    // Read address walks 0..N_TAPS-1 and parks on the last address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_p0  <= 1'b0;
            rd_addr_p0 <= '0;
        end else begin
            rd_vld_p0 <= (state_nxt == READ);
            if (start_load) begin
                rd_addr_p0 <= '0;
            end else if ((state == READ) && (rd_addr_p0 != LAST_ADDR)) begin
                rd_addr_p0 <= rd_addr_p0 + 1'b1;
            end
        end
    end

    // ---- stage p1: tap write, aligned with the memory's one-cycle read latency ----
    // Tap index follows the address issued one cycle earlier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
        end else begin
            wr_vld_p1 <= rd_vld_p0;
            if (rd_vld_p0) begin
                wr_addr_p1 <= rd_addr_p0;
            end
        end
    end

    // Post-load sample counter; cleared outside RUN and on a reload request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_cnt <= '0;
        end else if ((state != RUN) || load_req) begin
            smp_cnt <= '0;
        end else if (run_en) begin
            smp_cnt <= sat_inc(smp_cnt);
        end
    end

    assign mem_rd_en    = rd_vld_p0;
    assign mem_addr     = rd_addr_p0;
    assign tap_we       = wr_vld_p1;
    assign tap_addr     = wr_addr_p1;
    assign tap_data     = wr_vld_p1 ? mem_rdata : '0;

    assign coeff_loaded = (state == RUN);
    assign busy         = (state == READ) || (state == LAST);
    assign run_en       = x_valid_in & coeff_loaded;
    assign fir_en       = run_en;
    assign y_valid      = run_en & (smp_cnt >= CNT_FULL);

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Testbench for fir_coeff_sequencer: two instances (71 taps with auto-load,
// 4 taps without) driven with random samples and directed load/reset events,
// checked every cycle against a timeline-based reference model.
module tb_fir_coeff_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n [2];
    logic lreq  [2];
    logic xv    [2];

    logic       a_mem_rd_en, a_tap_we, a_fir_en, a_coeff_loaded, a_busy, a_y_valid;
    logic [6:0] a_mem_addr, a_tap_addr;
    logic [7:0] a_mem_rdata, a_tap_data;
    logic       b_mem_rd_en, b_tap_we, b_fir_en, b_coeff_loaded, b_busy, b_y_valid;
    logic [1:0] b_mem_addr, b_tap_addr;
    logic [7:0] b_mem_rdata, b_tap_data;

    logic [7:0] mem_a [128];
    logic [7:0] mem_b [4];

    fir_coeff_sequencer #(.N_TAPS(71), .COEFF_W(8), .ADDR_W(7), .AUTO_LOAD(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n[0]), .load_req(lreq[0]),
        .mem_rd_en(a_mem_rd_en), .mem_addr(a_mem_addr), .mem_rdata(a_mem_rdata),
        .tap_we(a_tap_we), .tap_addr(a_tap_addr), .tap_data(a_tap_data),
        .x_valid_in(xv[0]), .fir_en(a_fir_en), .coeff_loaded(a_coeff_loaded),
        .busy(a_busy), .y_valid(a_y_valid)
    );

    fir_coeff_sequencer #(.N_TAPS(4), .COEFF_W(8), .ADDR_W(2), .AUTO_LOAD(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n[1]), .load_req(lreq[1]),
        .mem_rd_en(b_mem_rd_en), .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata),
        .tap_we(b_tap_we), .tap_addr(b_tap_addr), .tap_data(b_tap_data),
        .x_valid_in(xv[1]), .fir_en(b_fir_en), .coeff_loaded(b_coeff_loaded),
        .busy(b_busy), .y_valid(b_y_valid)
    );

    // Synchronous-read coefficient memories.
    always @(posedge clk) begin
        if (a_mem_rd_en) a_mem_rdata <= mem_a[a_mem_addr];
        if (b_mem_rd_en) b_mem_rdata <= mem_b[b_mem_addr];
    end

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic        we;
        logic [31:0] taddr;
        logic [31:0] tdata;
        logic        fir;
        logic        cl;
        logic        busy;
        logic        yv;
    } obs_t;

    // Reference model: lc = cycles since load start (0 = not loading).
    typedef struct {
        int lc;
        bit run;
        int cnt;
        bit ap;
    } mdl_t;

    mdl_t  m [2];
    int    nt [2] = '{71, 4};
    bit    al [2] = '{1'b1, 1'b0};
    int    twe [2];
    int    bsy [2];
    int    checks = 0;
    int    errors = 0;
    int    rel_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int d, output obs_t o);
        if (d == 0) begin
            o.rd = a_mem_rd_en; o.addr = 32'(a_mem_addr); o.we = a_tap_we;
            o.taddr = 32'(a_tap_addr); o.tdata = 32'(a_tap_data); o.fir = a_fir_en;
            o.cl = a_coeff_loaded; o.busy = a_busy; o.yv = a_y_valid;
        end else begin
            o.rd = b_mem_rd_en; o.addr = 32'(b_mem_addr); o.we = b_tap_we;
            o.taddr = 32'(b_tap_addr); o.tdata = 32'(b_tap_data); o.fir = b_fir_en;
            o.cl = b_coeff_loaded; o.busy = b_busy; o.yv = b_y_valid;
        end
    endtask

    function automatic logic [31:0] memval(input int d, input int i);
        return (d == 0) ? 32'(mem_a[i]) : 32'(mem_b[i]);
    endfunction

    task automatic check_dut(input int d);
        obs_t  o;
        string p;
        int    lc, n;
        bit    e_rd, e_we, e_fir;
        p = (d == 0) ? "a" : "b";
        sample(d, o);
        if (!rst_n[d]) begin
            chk({p, "_rst_rd"}, 32'(o.rd), 0);
            chk({p, "_rst_addr"}, o.addr, 0);
            chk({p, "_rst_we"}, 32'(o.we), 0);
            chk({p, "_rst_taddr"}, o.taddr, 0);
            chk({p, "_rst_tdata"}, o.tdata, 0);
            chk({p, "_rst_fir"}, 32'(o.fir), 0);
            chk({p, "_rst_loaded"}, 32'(o.cl), 0);
            chk({p, "_rst_busy"}, 32'(o.busy), 0);
            chk({p, "_rst_yv"}, 32'(o.yv), 0);
            return;
        end
        lc = m[d].lc;
        n  = nt[d];
        e_rd = (lc >= 1) && (lc <= n);
        chk({p, "_mem_rd_en"}, 32'(o.rd), 32'(e_rd));
        if (e_rd) chk({p, "_mem_addr"}, o.addr, 32'(lc - 1));
        e_we = (lc >= 2) && (lc <= n + 1);
        chk({p, "_tap_we"}, 32'(o.we), 32'(e_we));
        if (e_we) begin
            chk({p, "_tap_addr"}, o.taddr, 32'(lc - 2));
            chk({p, "_tap_data"}, o.tdata, memval(d, lc - 2));
        end
        chk({p, "_busy"}, 32'(o.busy), 32'(lc != 0));
        chk({p, "_coeff_loaded"}, 32'(o.cl), 32'(m[d].run));
        e_fir = m[d].run && xv[d];
        chk({p, "_fir_en"}, 32'(o.fir), 32'(e_fir));
        chk({p, "_y_valid"}, 32'(o.yv), 32'(e_fir && (m[d].cnt >= n - 1)));
        if (o.we) twe[d]++;
        if (o.busy) bsy[d]++;
    endtask

    task automatic model_upd(input int d);
        int n;
        n = nt[d];
        if (!rst_n[d]) begin
            m[d].lc = 0; m[d].run = 1'b0; m[d].cnt = 0; m[d].ap = al[d];
            return;
        end
        if (m[d].lc != 0) begin
            m[d].lc++;
            if (m[d].lc > n + 1) begin
                m[d].lc = 0; m[d].run = 1'b1; m[d].cnt = 0;
            end
        end else if (m[d].run) begin
            if (xv[d]) m[d].cnt = (m[d].cnt + 1 > n) ? n : m[d].cnt + 1;
            if (lreq[d]) begin
                m[d].run = 1'b0; m[d].lc = 1; m[d].cnt = 0;
            end
        end else if (lreq[d] || m[d].ap) begin
            m[d].lc = 1;
        end
        m[d].ap = 1'b0;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        @(posedge clk);
        model_upd(0);
        model_upd(1);
        #1;
        rel_cyc++;
    endtask

    task automatic rnd_cycles(input int n, input int req_mod);
        for (int i = 0; i < n; i++) begin
            for (int d = 0; d < 2; d++) begin
                xv[d]   = ($urandom_range(0, 3) != 0);
                lreq[d] = (req_mod > 0) && ($urandom_range(0, req_mod - 1) == 0);
            end
            cycle();
        end
        lreq[0] = 1'b0;
        lreq[1] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem_a[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) mem_b[i] = 8'($urandom);
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; lreq[d] = 1'b0; xv[d] = 1'b0;
            twe[d] = 0; bsy[d] = 0;
            m[d].lc = 0; m[d].run = 1'b0; m[d].cnt = 0; m[d].ap = al[d];
        end

        // Reset held for a few cycles with inputs toggling.
        xv[0] = 1'b1; lreq[1] = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        xv[0] = 1'b0; lreq[1] = 1'b0;

        // Release both; the auto-load instance starts on the next edge.
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        rel_cyc = 0;
        twe[0] = 0; bsy[0] = 0;

        // Run a's load with random samples; request a reload mid-load.
        for (int i = 0; i < 200 && m[0].lc != 30; i++) begin
            xv[0] = ($urandom_range(0, 1) == 1);
            cycle();
        end
        lreq[0] = 1'b1;
        cycle();
        lreq[0] = 1'b0;
        for (int i = 0; i < 200 && !m[0].run; i++) begin
            xv[0] = ($urandom_range(0, 1) == 1);
            cycle();
        end
        @(negedge clk);
        chk("a_load_done", 32'(a_coeff_loaded), 1);
        chk("a_tap_writes", 32'(twe[0]), 71);
        chk("a_busy_cycles", 32'(bsy[0]), 72);
        @(posedge clk);
        #1;

        // b has no auto-load: stays idle until the request sampled at cycle 100.
        while (rel_cyc < 100) begin
            xv[0] = ($urandom_range(0, 1) == 1);
            xv[1] = ($urandom_range(0, 1) == 1);
            cycle();
        end
        lreq[1] = 1'b1;
        cycle();
        lreq[1] = 1'b0;

        rnd_cycles(20, 0);

        // Directed sample pattern on b: continuous, gap, continuous.
        for (int i = 0; i < 11; i++) begin
            xv[0] = 1'b1;
            xv[1] = (i < 6 || i >= 8);
            cycle();
        end

        // Reload while a sample is present: sample counted, then load restarts.
        lreq[0] = 1'b1; lreq[1] = 1'b1; xv[0] = 1'b1; xv[1] = 1'b1;
        cycle();
        lreq[0] = 1'b0; lreq[1] = 1'b0;
        for (int i = 0; i < 90; i++) cycle();
        rnd_cycles(120, 0);

        // Random traffic with occasional load requests.
        rnd_cycles(500, 40);

        // Asynchronous reset of a while tap 35 is being written.
        for (int i = 0; i < 200 && m[0].lc == 0; i++) begin
            lreq[0] = 1'b1;
            cycle();
        end
        lreq[0] = 1'b0;
        for (int i = 0; i < 200 && m[0].lc != 37; i++) cycle();
        @(negedge clk);
        chk("a_tap_addr_at_reset", 32'(a_tap_addr), 35);
        check_dut(0);
        check_dut(1);
        #2;
        rst_n[0] = 1'b0;
        #1;
        check_dut(0);
        @(posedge clk);
        model_upd(0);
        model_upd(1);
        #1;
        cycle();
        cycle();
        rst_n[0] = 1'b1;
        twe[0] = 0; bsy[0] = 0;
        for (int i = 0; i < 200 && !m[0].run; i++) begin
            xv[0] = ($urandom_range(0, 1) == 1);
            cycle();
        end
        @(negedge clk);
        chk("a_reload_done", 32'(a_coeff_loaded), 1);
        chk("a_reload_tap_writes", 32'(twe[0]), 71);
        chk("a_reload_busy_cycles", 32'(bsy[0]), 72);
        @(posedge clk);
        #1;
        rnd_cycles(100, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_coeff_sequencer.md
Name: fir_coeff_sequencer

Overview:
Controller that loads the FIR filter's coefficient registers from the coefficient register array and gates sample flow into the filter.
- After reset (optionally) or on request, it reads N_TAPS coefficients sequentially from a synchronous-read coefficient memory and writes each one to the matching tap.
- It holds the filter disabled until loading completes, then enables sample shifting.
- It flags when the tap delay line holds a full window of post-load samples.
- It sits between the coefficient store and the FIR filter's DSP-slice chain.

Parameters:
- N_TAPS, 71, number of taps/coefficients to load (≥2).
- COEFF_W, 8, coefficient width.
- ADDR_W, 7, address width; 2^ADDR_W ≥ N_TAPS.
- AUTO_LOAD, 1, if 1, a load starts automatically after reset release.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- load_req  in  1  request a (re)load; sampled every cycle.
- mem_rd_en  out  1  coefficient memory read strobe.
- mem_addr  out  ADDR_W  coefficient memory read address.
- mem_rdata  in  COEFF_W  read data, valid the cycle after mem_rd_en.
- tap_we  out  1  tap coefficient write enable.
- tap_addr  out  ADDR_W  tap index being written.
- tap_data  out  COEFF_W  coefficient value for tap_addr.
- x_valid_in  in  1  input sample valid from the upstream mapper.
- fir_en  out  1  filter shift/accumulate enable.
- coeff_loaded  out  1  all taps hold current coefficients.
- busy  out  1  load in progress.
- y_valid  out  1  filter window full; output meaningful.

Behaviour:
- Reset (async assert, sync release):
  - mem_rd_en, tap_we, fir_en, coeff_loaded, busy, y_valid = 0.
  - mem_addr, tap_addr, tap_data = 0.
  - State IDLE; sample counter = 0.
- States are IDLE, READ, LAST, RUN.
- IDLE:
  - Go to READ on load_req=1.
  - If AUTO_LOAD=1, also go to READ on the first clock edge after reset release, whether or not load_req is high.
- Timeline: let cycle k be the edge on which the start is sampled.
  - Cycles k+1..k+N_TAPS: state READ. mem_rd_en=1, mem_addr=0,1,...,N_TAPS-1 (one per cycle, all registered outputs).
  - Cycles k+2..k+N_TAPS+1: tap_we=1, tap_addr = previous cycle's mem_addr, tap_data = mem_rdata (passed through combinationally from the memory). Cycle k+N_TAPS+1 is state LAST, with mem_rd_en=0.
  - busy=1 for cycles k+1..k+N_TAPS+1.
  - Cycle k+N_TAPS+2: state RUN, coeff_loaded=1, busy=0, tap_we=0.
  - Load duration is N_TAPS+1 cycles; no gaps between reads.
- load_req while busy (READ/LAST): ignored; no restart, no queueing.
- load_req in RUN: next cycle enters READ.
  - coeff_loaded, fir_en and y_valid drop to 0 in that same cycle.
  - Sample counter clears to 0.
- RUN:
  - fir_en = x_valid_in & coeff_loaded (combinational).
  - The sample counter increments on each fir_en cycle and saturates at N_TAPS.
  - y_valid = fir_en & (counter ≥ N_TAPS-1): asserted with the N_TAPS-th enabled sample after load and every enabled sample thereafter.
- fir_en is 0 in every state other than RUN; x_valid_in outside RUN is dropped and not counted.
- Address wrap: mem_addr never exceeds N_TAPS-1; the read counter stops at N_TAPS-1, with no wrap to 0 within a load.
- Reset mid-load:
  - Immediate return to reset values.
  - Partially written taps are left as-is, but coeff_loaded=0 until a full load completes.
  - AUTO_LOAD re-triggers the load after reset release.
- Simultaneous load_req and x_valid_in in RUN: the reload wins in the following cycle. The sample in the current cycle is still enabled (fir_en=1) and counted.

Test Plan:
1. AUTO_LOAD=1, N_TAPS=71, memory holds addr+1. Release rst_n at cycle 0 → mem_addr 0..70 in cycles 1..71; tap_we cycles 2..72 with tap_data=tap_addr+1; coeff_loaded=1 at cycle 73; busy high exactly 72 cycles.
2. AUTO_LOAD=0 → stays IDLE (busy=0, mem_rd_en=0) for 100 cycles. load_req pulse at cycle 100 → first mem_rd_en at 101; coeff_loaded at 173.
3. N_TAPS=4, after load, x_valid_in high continuously → fir_en tracks x_valid_in; y_valid low for the first 3 enabled samples, high from the 4th onward. A gap in x_valid_in drops fir_en and y_valid but keeps the count.
4. load_req asserted at cycle 30 of an active load → ignored; load completes on original schedule; exactly N_TAPS tap writes.
5. load_req in RUN with x_valid_in=1 → the current sample is enabled. The next cycle shows coeff_loaded=0, fir_en=0, y_valid=0. A full reload follows, and y_valid requires N_TAPS new samples.
6. rst_n pulsed low at tap_addr=35 during a load → outputs go to reset values asynchronously; a fresh load starts from addr 0 after release (AUTO_LOAD=1).
